// File: rtl/xregf_wr_arb.sv
// Write-port arbiter for the Versat register file: merges host and engine
// writes into one registered write per cycle, host-first with engine anti-starvation.
module xregf_wr_arb #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 4,
    parameter int MAX_WAIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              host_req,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_data,
    output logic              host_ack,
    input  logic              eng_req,
    input  logic [ADDR_W-1:0] eng_addr,
    input  logic [DATA_W-1:0] eng_data,
    output logic              eng_ack,
    output logic              regf_we,
    output logic [ADDR_W-1:0] regf_addr,
    output logic [DATA_W-1:0] regf_data,
    input  logic              cnt_clr,
    output logic [7:0]        conflict_cnt
);

    localparam logic [3:0] WAIT_LIM = 4'(MAX_WAIT);

    logic              regf_we_q, regf_we_d;
    logic [ADDR_W-1:0] regf_addr_q, regf_addr_d;
    logic [DATA_W-1:0] regf_data_q, regf_data_d;
    logic [3:0]        eng_wait_q, eng_wait_d;
    logic [7:0]        cnt_q, cnt_d;
    logic              eng_prio;

    // Grants depend only on requests and internal wait state, never on regf_* outputs.
    always_comb begin
        eng_prio = (eng_wait_q >= WAIT_LIM);
        host_ack = ~rst & host_req & ~(eng_req & eng_prio);
        eng_ack  = ~rst & eng_req & (~host_req | eng_prio);
    end

    always_comb begin
        regf_we_d   = host_ack | eng_ack;
        regf_addr_d = regf_addr_q;
        regf_data_d = regf_data_q;
        if (host_ack) begin
            regf_addr_d = host_addr;
            regf_data_d = host_data;
        end else if (eng_ack) begin
            regf_addr_d = eng_addr;
            regf_data_d = eng_data;
        end

        eng_wait_d = eng_wait_q;
        if (!eng_req || eng_ack) begin
            eng_wait_d = '0;
        end else if (eng_wait_q < WAIT_LIM) begin
            eng_wait_d = eng_wait_q + 4'd1;
        end

        cnt_d = cnt_q;
        if (cnt_clr) begin
            cnt_d = '0;
        end else if (host_req && eng_req && cnt_q != 8'hFF) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            regf_we_q   <= 1'b0;
            regf_addr_q <= '0;
            regf_data_q <= '0;
            eng_wait_q  <= '0;
            cnt_q       <= '0;
        end else begin
            regf_we_q   <= regf_we_d;
            regf_addr_q <= regf_addr_d;
            regf_data_q <= regf_data_d;
            eng_wait_q  <= eng_wait_d;
            cnt_q       <= cnt_d;
        end
    end

    assign regf_we      = regf_we_q;
    assign regf_addr    = regf_addr_q;
    assign regf_data    = regf_data_q;
    assign conflict_cnt = cnt_q;

endmodule

// File: tb/tb_xregf_wr_arb.sv
// Scoreboard bench for xregf_wr_arb: two instances (MAX_WAIT=4 and MAX_WAIT=1)
// share stimulus; a per-instance grant model predicts acks, counter and writes.
module tb_xregf_wr_arb;

    typedef struct {
        logic [3:0]  a;
        logic [31:0] d;
        int          cyc;
    } wr_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic hreq = 1'b0, ereq = 1'b0, clr = 1'b0;
    logic [3:0]  haddr = '0, eaddr = '0;
    logic [31:0] hdata = '0, edata = '0;

    logic [1:0]       ha, ea, we;
    logic [1:0][3:0]  wa;
    logic [1:0][31:0] wd;
    logic [1:0][7:0]  cc;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    wr_t  exq [2][$];
    int   lost [2];
    int   cnt_m [2];
    int   mw [2] = '{4, 1};
    bit   last_h [2], last_e [2];
    logic [31:0] rf [2][16];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    xregf_wr_arb #(.DATA_W(32), .ADDR_W(4), .MAX_WAIT(4)) dut4 (
        .clk(clk), .rst(rst),
        .host_req(hreq), .host_addr(haddr), .host_data(hdata), .host_ack(ha[0]),
        .eng_req(ereq), .eng_addr(eaddr), .eng_data(edata), .eng_ack(ea[0]),
        .regf_we(we[0]), .regf_addr(wa[0]), .regf_data(wd[0]),
        .cnt_clr(clr), .conflict_cnt(cc[0])
    );

    xregf_wr_arb #(.DATA_W(32), .ADDR_W(4), .MAX_WAIT(1)) dut1 (
        .clk(clk), .rst(rst),
        .host_req(hreq), .host_addr(haddr), .host_data(hdata), .host_ack(ha[1]),
        .eng_req(ereq), .eng_addr(eaddr), .eng_data(edata), .eng_ack(ea[1]),
        .regf_we(we[1]), .regf_addr(wa[1]), .regf_data(wd[1]),
        .cnt_clr(clr), .conflict_cnt(cc[1])
    );

    // Register file fed by each instance's write port.
    always @(posedge clk) begin
        for (int unsigned k = 0; k < 2; k++)
            if (we[k] === 1'b1) rf[k][wa[k]] <= wd[k];
    end

    task automatic chk(string name, int k, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[dut%0d] cyc %0d: got %0h expected %0h", name, k, cyc, act, exp);
        end
    endtask

    // Monitor: every regf_we must match the oldest expected write, one cycle after its grant.
    always @(negedge clk) begin
        for (int unsigned k = 0; k < 2; k++) begin
            while (exq[k].size() > 0 && exq[k][0].cyc < cyc - 1) begin
                checks++; errors++;
                $display("FAIL missing_write[dut%0d] cyc %0d: got no regf_we expected write granted in cyc %0d",
                         k, cyc, exq[k][0].cyc);
                void'(exq[k].pop_front());
            end
            if (we[k] === 1'b1) begin
                if (exq[k].size() == 0 || exq[k][0].cyc != cyc - 1) begin
                    checks++; errors++;
                    $display("FAIL unexpected_write[dut%0d] cyc %0d: got regf_we=1 addr %0h expected none",
                             k, cyc, wa[k]);
                end else begin
                    wr_t e;
                    e = exq[k].pop_front();
                    chk("regf_addr", k, 32'(wa[k]), 32'(e.a));
                    chk("regf_data", k, wd[k], e.d);
                end
            end
        end
    end

    // Model: engine wins a conflict once it has lost at least MAX_WAIT cycles in a row.
    task automatic eval();
        @(negedge clk);
        for (int unsigned k = 0; k < 2; k++) begin
            bit ew, eh;
            ew = ereq && (!hreq || lost[k] >= mw[k]);
            eh = hreq && !ew;
            chk("host_ack", k, 32'(ha[k]), 32'(eh));
            chk("eng_ack", k, 32'(ea[k]), 32'(ew));
            chk("conflict_cnt", k, 32'(cc[k]), 32'(cnt_m[k]));
            if (eh) exq[k].push_back('{haddr, hdata, cyc});
            if (ew) exq[k].push_back('{eaddr, edata, cyc});
            lost[k] = (ereq && !ew) ? lost[k] + 1 : 0;
            if (clr) cnt_m[k] = 0;
            else if (hreq && ereq && cnt_m[k] < 255) cnt_m[k] = cnt_m[k] + 1;
            last_h[k] = eh;
            last_e[k] = ew;
        end
    endtask

    task automatic cycle(bit h, bit e, logic [3:0] ah, logic [31:0] dh,
                         logic [3:0] ae, logic [31:0] de, bit c);
        @(posedge clk); #1;
        hreq = h; ereq = e; haddr = ah; hdata = dh; eaddr = ae; edata = de; clr = c;
        eval();
    endtask

    task automatic rcycle(bit h, bit e, bit c);
        cycle(h, e, 4'($urandom), $urandom, 4'($urandom), $urandom, c);
    endtask

    initial begin
        for (int unsigned k = 0; k < 2; k++) begin
            lost[k] = 0; cnt_m[k] = 0;
            for (int unsigned j = 0; j < 16; j++) rf[k][j] = '0;
        end
        hreq = 1'b1;
        #12;
        for (int unsigned k = 0; k < 2; k++) begin
            chk("rst_host_ack", k, 32'(ha[k]), 0);
            chk("rst_regf_we", k, 32'(we[k]), 0);
            chk("rst_conflict_cnt", k, 32'(cc[k]), 0);
        end
        @(posedge clk); #1;
        rst = 1'b0; hreq = 1'b0;

        // Solo writes
        cycle(1, 0, 4'd3, 32'hDEADBEEF, 4'd0, 32'h0, 0);
        cycle(0, 1, 4'd0, 32'h0, 4'd5, 32'h12345678, 0);
        for (int unsigned k = 0; k < 2; k++) begin
            chk("solo_eng_ack", k, 32'(ea[k]), 1);
            chk("solo_host_wr", k, wd[k], 32'hDEADBEEF);
        end
        cycle(0, 0, 4'd0, 32'h0, 4'd0, 32'h0, 0);
        for (int unsigned k = 0; k < 2; k++) chk("solo_eng_wr", k, 32'(wa[k]), 5);

        // Continuous conflict: host x4 then eng (MAX_WAIT=4); strict alternation (MAX_WAIT=1)
        for (int unsigned i = 0; i < 10; i++) begin
            rcycle(1, 1, 0);
            chk("seq_mw4", 0, 32'(last_e[0]), 32'(i % 5 == 4));
            chk("seq_mw1", 1, 32'(last_e[1]), 32'(i % 2 == 1));
            chk("no_bubble", 1, 32'(ha[1] | ea[1]), 1);
            chk("ack_excl", 1, 32'(ha[1] & ea[1]), 0);
        end
        rcycle(0, 0, 0);

        // Same-address conflict: host value first, engine value last
        cycle(1, 1, 4'd7, 32'hAAAA, 4'd7, 32'h5555, 0);
        cycle(0, 1, 4'd0, 32'h0, 4'd7, 32'h5555, 0);
        for (int unsigned k = 0; k < 2; k++) chk("same_addr_first", k, wd[k], 32'hAAAA);
        cycle(0, 0, 4'd0, 32'h0, 4'd0, 32'h0, 0);
        for (int unsigned k = 0; k < 2; k++) chk("same_addr_second", k, wd[k], 32'h5555);
        cycle(0, 0, 4'd0, 32'h0, 4'd0, 32'h0, 0);
        for (int unsigned k = 0; k < 2; k++) chk("rf_addr7", k, rf[k][7], 32'h5555);

        // Counter saturation and clear
        for (int unsigned i = 0; i < 300; i++) rcycle(1, 1, 0);
        for (int unsigned k = 0; k < 2; k++) chk("cnt_sat", k, 32'(cc[k]), 255);
        rcycle(1, 1, 1);
        rcycle(1, 1, 0);
        for (int unsigned k = 0; k < 2; k++) chk("cnt_clr0", k, 32'(cc[k]), 0);
        rcycle(1, 1, 0);
        for (int unsigned k = 0; k < 2; k++) chk("cnt_resume1", k, 32'(cc[k]), 1);

        // Random traffic
        for (int unsigned i = 0; i < 400; i++)
            rcycle($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                   $urandom_range(0, 31) == 0);

        // Asynchronous reset mid-cycle with a write in flight
        rcycle(1, 1, 0);
        @(posedge clk); #1;
        hreq = 1'b1; ereq = 1'b0; clr = 1'b0;
        #2 rst = 1'b1;
        #1;
        for (int unsigned k = 0; k < 2; k++) begin
            chk("midrst_host_ack", k, 32'(ha[k]), 0);
            chk("midrst_eng_ack", k, 32'(ea[k]), 0);
            chk("midrst_regf_we", k, 32'(we[k]), 0);
            chk("midrst_cnt", k, 32'(cc[k]), 0);
            exq[k].delete();
            lost[k] = 0;
            cnt_m[k] = 0;
        end
        @(posedge clk); #1;
        rst = 1'b0;
        eval();
        for (int unsigned k = 0; k < 2; k++) chk("post_rst_host_grant", k, 32'(ha[k]), 1);

        for (int unsigned i = 0; i < 3; i++) rcycle(0, 0, 0);
        for (int unsigned k = 0; k < 2; k++) chk("queue_drained", k, exq[k].size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/xregf_wr_arb.md
# xregf_wr_arb

Write-port arbiter for the Versat register file. It sits between the host interface and the Versat engine and issues one registered write per cycle into the register file's single write port. Simultaneous write attempts are never dropped: the requester that loses waits, with host priority bounded by an anti-starvation counter for the engine. Reads bypass this block and go directly to the register file.

## Interface
- `DATA_W`, default 32: data width; matches `` `DATA_W ``.
- `ADDR_W`, default 4: register address width; matches `` `REGF_ADDR_W ``.
- `MAX_WAIT`, default 4, legal range 1..15: number of lost conflict cycles after which the engine wins.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: reset, asynchronous and active-high.
- `host_req` input 1: host write request; held until `host_ack`.
- `host_addr` input ADDR_W: host write address; stable while `host_req` is high.
- `host_data` input DATA_W: host write data; stable while `host_req` is high.
- `host_ack` output 1: combinational grant to the host, one cycle per accepted write.
- `eng_req` input 1: engine write request, i.e. `int_sel & int_we`; held until `eng_ack`.
- `eng_addr` input ADDR_W: engine write address.
- `eng_data` input DATA_W: engine write data.
- `eng_ack` output 1: combinational grant to the engine.
- `regf_we` output 1: registered write enable to the register file.
- `regf_addr` output ADDR_W: registered write address.
- `regf_data` output DATA_W: registered write data.
- `cnt_clr` input 1: synchronous clear of `conflict_cnt`.
- `conflict_cnt` output 8: saturating count of cycles in which both requesters were active.

## Operation
- Grant, combinational each cycle:
  - Only `host_req` is high: `host_ack`=1.
  - Only `eng_req` is high: `eng_ack`=1.
  - Both are high: the host wins unless `eng_wait >= MAX_WAIT`, in which case the engine wins.
  - `host_ack` and `eng_ack` are never high together.
  - Both acks are 0 while `rst` is high.
- Write stage, on the rising edge:
  - `regf_we` <= `host_ack | eng_ack`.
  - `regf_addr` and `regf_data` <= the granted requester's addr/data.
  - When there is no grant, `regf_addr` and `regf_data` hold their previous values.
- Requester protocol:
  - A requester sees its ack in cycle t.
  - In cycle t+1 it either deasserts req or presents its next write.
  - Back-to-back writes from one requester therefore run at one per cycle.
- `eng_wait` counter, 4 bits, internal:
  - Increments when `eng_req & ~eng_ack`.
  - Saturates at `MAX_WAIT`.
  - Clears to 0 on `eng_ack` or when `eng_req` is 0.
- `conflict_cnt`:
  - Increments on `host_req & eng_req` and saturates at 255.
  - `cnt_clr` takes priority over the increment: if both occur in the same cycle, the result is 0.
- Reset values: `regf_we`=0, `regf_addr`=0, `regf_data`=0, `eng_wait`=0, `conflict_cnt`=0.
- Reset mid-operation: any in-flight write is discarded. Requesters re-present after reset, because they never saw an ack for it.
- Same-address conflict: both writes are performed, in grant order. The last-granted value is the final content.

## Timing
- Request to ack: 0 cycles (combinational), provided the request is uncontested or wins.
- Ack to `regf_we`: 1 cycle. The register file captures the write at the following edge, so a read of that address returns new data 2 edges after the ack edge.
- Engine worst-case wait under continuous host traffic: `MAX_WAIT` cycles, then a grant.
- With `MAX_WAIT`=1 and both requesting continuously, grants alternate host, eng, host, eng.
- Throughput: one write per cycle sustained. There are no bubbles between grants to different requesters.
- No combinational path exists from the `regf_*` outputs back to the acks.

## Test plan
- Reset: assert `rst` asynchronously mid-cycle while `host_req`=1.
  - Required: `regf_we`=0, `conflict_cnt`=0 and both acks 0 immediately.
  - Required: after release, the host is granted on the first cycle.
- Solo writes: host writes addr 3 = 0xDEADBEEF, then the engine writes addr 5 = 0x12345678.
  - Required: each ack is seen in its request cycle.
  - Required: `regf_we` pulses one cycle later with the matching addr/data.
- Conflict, `MAX_WAIT`=4: host and engine request continuously.
  - Required grant sequence: host ×4, eng, host ×4, eng.
  - Required: `conflict_cnt` increments every cycle.
- Conflict, `MAX_WAIT`=1: both request continuously.
  - Required: strict alternation.
  - Required: no cycle without a grant, and both acks never high together.
- Same address: both write addr 7 in the same cycle, host 0xAAAA, eng 0x5555.
  - Required: 0xAAAA is written first, 0x5555 next cycle.
  - Required: the register-file read of addr 7 finally returns 0x5555.
- Counter: hold both requests for 300 cycles.
  - Required: `conflict_cnt` saturates at 255.
  - Required: `cnt_clr` asserted in a conflicting cycle gives 0 at the next edge, then the count resumes at 1.
